// File: rtl/spi_fifo_master.sv
// Byte-wide SPI master with TX/RX FIFOs, programmable SCLK polarity/phase and divider.
// Optional build macro SPI_LOOPBACK_EN: the receive shifter samples mosi instead of miso.
module spi_fifo_master #(
    parameter int DIV        = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       raw_clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_push,
    output logic       tx_full,
    output logic [7:0] rx_data,
    input  logic       rx_pop,
    output logic       rx_empty,
    input  logic       cpol,
    input  logic       cpha,
    output logic       busy,
    output logic       overrun,
    input  logic       clear_overrun,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW    = DEPTH_LOG2 + 1;

    state_t                state;
    logic [7:0]            tx_mem [FIFO_DEPTH];
    logic [7:0]            rx_mem [FIFO_DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CW-1:0]         tx_count, rx_count;
    logic [DIV_W-1:0]      div_cnt;
    logic [3:0]            toggle_cnt;
    logic [7:0]            tx_shift, rx_shift;
    logic                  lat_cpha;
    logic                  tx_empty, rx_full;
    logic                  tx_acc, tx_take, rx_put, rx_take;
    logic                  sample_bit;

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign sample_bit  = mosi;
`else
    assign sample_bit  = miso;
`endif

    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == CW'(FIFO_DEPTH));
    assign rx_data  = rx_mem[rx_rd];
    assign busy     = (state != IDLE) || !tx_empty;

    assign tx_acc  = tx_push && !tx_full;
    assign tx_take = (state == LOAD);
    assign rx_put  = (state == DONE) && !rx_full;
    assign rx_take = rx_pop && !rx_empty;

    // Storage arrays carry no reset; only the pointers and counts define their contents.
    always_ff @(posedge raw_clk) begin
        if (!reset && tx_acc) tx_mem[tx_wr] <= tx_data;
        if (!reset && rx_put) rx_mem[rx_wr] <= rx_shift;
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state      <= IDLE;
            tx_wr      <= '0;
            tx_rd      <= '0;
            rx_wr      <= '0;
            rx_rd      <= '0;
            tx_count   <= '0;
            rx_count   <= '0;
            div_cnt    <= '0;
            toggle_cnt <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            lat_cpha   <= 1'b0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (tx_acc)  tx_wr <= tx_wr + DEPTH_LOG2'(1);
            if (tx_take) tx_rd <= tx_rd + DEPTH_LOG2'(1);
            if (rx_put)  rx_wr <= rx_wr + DEPTH_LOG2'(1);
            if (rx_take) rx_rd <= rx_rd + DEPTH_LOG2'(1);
            tx_count <= tx_count + CW'(tx_acc) - CW'(tx_take);
            rx_count <= rx_count + CW'(rx_put) - CW'(rx_take);

            if (state == DONE && rx_full)
                overrun <= 1'b1;
            else if (clear_overrun)
                overrun <= 1'b0;

            case (state)
                IDLE: begin
                    sclk <= cpol;
                    if (!tx_empty) state <= LOAD;
                end
                LOAD: begin
                    lat_cpha   <= cpha;
                    sclk       <= cpol;
                    div_cnt    <= '0;
                    toggle_cnt <= '0;
                    if (!cpha) begin
                        mosi     <= tx_mem[tx_rd][7];
                        tx_shift <= {tx_mem[tx_rd][6:0], 1'b0};
                    end else begin
                        tx_shift <= tx_mem[tx_rd];
                    end
                    state <= SHIFT;
                end
                SHIFT: begin
                    // Even toggle_cnt means the upcoming toggle is a leading edge.
                    if (div_cnt == DIV_W'(DIV - 1)) begin
                        div_cnt    <= '0;
                        sclk       <= ~sclk;
                        toggle_cnt <= toggle_cnt + 4'd1;
                        if (toggle_cnt[0] == lat_cpha) begin
                            rx_shift <= {rx_shift[6:0], sample_bit};
                        end else begin
                            mosi     <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                        if (toggle_cnt == 4'd15) state <= DONE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                DONE: begin
                    state <= tx_empty ? IDLE : LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_fifo_master.sv
// Bench for spi_fifo_master: an SPI slave model drives miso and captures mosi,
// and queues hold the bytes expected on the RX side and on the wire.
`timescale 1ns/1ps
module tb_spi_fifo_master;
    localparam int DIV         = 4;
    localparam int DEPTH       = 4;
    localparam int BYTE_CYCLES = 2 + 16 * DIV;

    logic       raw_clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_push;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_pop;
    logic       rx_empty;
    logic       cpol;
    logic       cpha;
    logic       busy;
    logic       overrun;
    logic       clear_overrun;
    logic       sclk;
    logic       mosi;
    logic       miso;

    int checks = 0;
    int errors = 0;

    logic [7:0] miso_q[$];
    logic [7:0] cap_q[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_cap[$];
    logic [7:0] s_pat;
    logic [7:0] s_cap;
    int         ec;
    bit         slave_en = 1'b0;
    logic       s_cpha = 1'b0;

    spi_fifo_master #(.DIV(DIV), .FIFO_DEPTH(DEPTH), .DEPTH_LOG2(2)) dut (
        .raw_clk(raw_clk), .reset(reset), .tx_data(tx_data), .tx_push(tx_push),
        .tx_full(tx_full), .rx_data(rx_data), .rx_pop(rx_pop), .rx_empty(rx_empty),
        .cpol(cpol), .cpha(cpha), .busy(busy), .overrun(overrun),
        .clear_overrun(clear_overrun), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    always #5 raw_clk = ~raw_clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic slaveLoad();
        ec    = 0;
        s_cap = 8'h00;
        if (miso_q.size() > 0) s_pat = miso_q.pop_front();
        else                   s_pat = 8'h00;
        miso = s_pat[7];
    endtask

    // Slave: counts SCLK edges per byte, samples mosi on the mode's sample edge.
    always @(sclk) begin
        if (slave_en) begin
            int idx;
            ec++;
            if ((!s_cpha && ec[0]) || (s_cpha && !ec[0]))
                s_cap = {s_cap[6:0], mosi};
            if (ec == 16) begin
                cap_q.push_back(s_cap);
                slaveLoad();
            end else begin
                idx  = s_cpha ? (ec - 1) / 2 : ec / 2;
                miso = s_pat[7 - idx];
            end
        end
    end

    task automatic tick();
        @(posedge raw_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] tx, input logic [7:0] pat, input bit accept);
        tx_data = tx;
        tx_push = 1'b1;
        if (accept) begin
            miso_q.push_back(pat);
            exp_cap.push_back(tx);
`ifdef SPI_LOOPBACK_EN
            exp_rx.push_back(tx);
`else
            exp_rx.push_back(pat);
`endif
        end
        if (!slave_en) begin
            slaveLoad();
            slave_en = 1'b1;
        end
    endtask

    task automatic setMode(input logic pol, input logic pha);
        slave_en = 1'b0;
        cpol     = pol;
        cpha     = pha;
        s_cpha   = pha;
        repeat (3) tick();
        checkOutput("idle_sclk", 32'(sclk), 32'(pol));
    endtask

    task automatic popRx(input string tag);
        checkOutput({tag, "_rx"}, 32'(rx_data), 32'(exp_rx.pop_front()));
        rx_pop = 1'b1;
    endtask

    task automatic drain(input string tag, input int limit);
        int n = 0;
        while ((exp_rx.size() > 0 || busy) && n < limit) begin
            rx_pop = 1'b0;
            if (!rx_empty && exp_rx.size() > 0) popRx(tag);
            tick();
            n++;
        end
        rx_pop = 1'b0;
        checkOutput({tag, "_done"}, 32'(exp_rx.size()) + 32'(busy), 32'd0);
    endtask

    task automatic checkCaptures(input string tag);
        checkOutput({tag, "_ncap"}, 32'(cap_q.size()), 32'(exp_cap.size()));
        while (cap_q.size() > 0 && exp_cap.size() > 0)
            checkOutput({tag, "_mosi"}, 32'(cap_q.pop_front()), 32'(exp_cap.pop_front()));
        cap_q.delete();
        exp_cap.delete();
    endtask

    initial begin
        int         n;
        int         n_sent;
        int         n_busy;
        logic [1:0] mode_r;
        logic       exp_ovr;

        reset = 1'b1; tx_data = 8'h00; tx_push = 1'b0; rx_pop = 1'b0;
        cpol = 1'b0; cpha = 1'b0; clear_overrun = 1'b0; miso = 1'b0;
        repeat (3) tick();
        checkOutput("rst_sclk", 32'(sclk), 32'd0);
        checkOutput("rst_mosi", 32'(mosi), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rx_empty", 32'(rx_empty), 32'd1);
        checkOutput("rst_tx_full", 32'(tx_full), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick();

        // Mode 0 single byte with exact completion latency.
        setMode(1'b0, 1'b0);
        applyStimulus(8'hA5, 8'hA5, 1'b1);
        tick();
        tx_push = 1'b0;
        repeat (BYTE_CYCLES) tick();
        checkOutput("lat_before", 32'(rx_empty), 32'd1);
        checkOutput("busy_mid", 32'(busy), 32'd1);
        tick();
        checkOutput("lat_after", 32'(rx_empty), 32'd0);
        tick();
        checkOutput("busy_end", 32'(busy), 32'd0);
        drain("mode0", 50);
        checkCaptures("mode0");

        // Mode 3.
        setMode(1'b1, 1'b1);
        applyStimulus(8'h3C, 8'hC3, 1'b1);
        tick();
        tx_push = 1'b0;
        drain("mode3", 200);
        checkCaptures("mode3");
        checkOutput("mode3_sclk_idle", 32'(sclk), 32'd1);

        // Random data across all four modes.
        for (int r = 0; r < 8; r++) begin
            mode_r = 2'(r);
            setMode(mode_r[1], mode_r[0]);
            applyStimulus(8'($urandom), 8'($urandom), 1'b1);
            tick();
            tx_push = 1'b0;
            drain("rand", 200);
            checkCaptures("rand");
            checkOutput("rand_sclk_idle", 32'(sclk), 32'(mode_r[1]));
        end

        // Five back-to-back bytes: busy must stay high for exactly five byte times.
        setMode(1'b0, 1'b0);
        n = 0; n_sent = 0; n_busy = 0;
        while ((n_sent < 5 || exp_rx.size() > 0 || busy) && n < 1000) begin
            tx_push = 1'b0;
            rx_pop  = 1'b0;
            if (n_sent < 5 && !tx_full) begin
                applyStimulus(8'($urandom), 8'($urandom), 1'b1);
                n_sent++;
            end
            if (!rx_empty && exp_rx.size() > 0) popRx("b2b");
            tick();
            n++;
            if (busy) n_busy++;
        end
        tx_push = 1'b0;
        rx_pop  = 1'b0;
        checkOutput("b2b_done", 32'(exp_rx.size()) + 32'(busy), 32'd0);
        checkOutput("b2b_busy_cycles", 32'(n_busy), 32'(1 + 5 * BYTE_CYCLES));
        checkCaptures("b2b");

        // TX full while a byte is shifting; a push into a full FIFO is dropped.
        setMode(1'b0, 1'b0);
        applyStimulus(8'($urandom), 8'($urandom), 1'b1);
        tick();
        tx_push = 1'b0;
        repeat (8) tick();
        checkOutput("tx_not_full", 32'(tx_full), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'b1);
            tick();
        end
        tx_push = 1'b0;
        checkOutput("tx_full", 32'(tx_full), 32'd1);
        applyStimulus(8'hE7, 8'h18, 1'b0);
        tick();
        tx_push = 1'b0;
        checkOutput("tx_full_hold", 32'(tx_full), 32'd1);
        drain("full", 2000);
        repeat (4) tick();
        checkOutput("full_rx_empty", 32'(rx_empty), 32'd1);
        checkCaptures("full");

        // RX overrun: five bytes, no pops.
        setMode(1'b0, 1'b0);
        n = 0; n_sent = 0;
        while ((n_sent < 5 || busy) && n < 1000) begin
            tx_push = 1'b0;
            if (n_sent < 5 && !tx_full) begin
                applyStimulus(8'($urandom), 8'($urandom), 1'b1);
                n_sent++;
            end
            tick();
            n++;
        end
        tx_push = 1'b0;
        checkOutput("ovr_idle", 32'(busy), 32'd0);
        exp_ovr = (exp_rx.size() > DEPTH);
        while (exp_rx.size() > DEPTH) void'(exp_rx.pop_back());
        checkOutput("ovr_set", 32'(overrun), 32'(exp_ovr));
        for (int i = 0; i < DEPTH; i++) begin
            rx_pop = 1'b0;
            popRx("ovr");
            tick();
        end
        rx_pop = 1'b0;
        checkOutput("ovr_rx_empty", 32'(rx_empty), 32'd1);
        checkOutput("ovr_sticky", 32'(overrun), 32'(exp_ovr));
        checkCaptures("ovr");
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        checkOutput("pop_empty", 32'(rx_empty), 32'd1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        checkOutput("ovr_clear", 32'(overrun), 32'd0);
        setMode(1'b0, 1'b0);
        applyStimulus(8'($urandom), 8'($urandom), 1'b1);
        tick();
        tx_push = 1'b0;
        drain("after_ovr", 200);
        checkOutput("after_ovr_empty", 32'(rx_empty), 32'd1);
        checkCaptures("after_ovr");

        // Reset in the middle of the second byte, first byte left in RX.
        setMode(1'b0, 1'b0);
        applyStimulus(8'h3C, 8'h00, 1'b0);
        tick();
        applyStimulus(8'hFF, 8'h00, 1'b0);
        tick();
        tx_push = 1'b0;
        n = 0;
        while (!(cap_q.size() == 1 && ec >= 5) && n < 400) begin
            tick();
            n++;
        end
        checkOutput("pre_rst_rx", 32'(rx_empty), 32'd0);
        checkOutput("pre_rst_sclk", 32'(sclk), 32'd1);
        checkOutput("pre_rst_mosi", 32'(mosi), 32'd1);
        slave_en = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_rst_sclk", 32'(sclk), 32'd0);
        checkOutput("mid_rst_mosi", 32'(mosi), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_rx_empty", 32'(rx_empty), 32'd1);
        checkOutput("mid_rst_tx_full", 32'(tx_full), 32'd0);
        repeat (100) tick();
        checkOutput("post_rst_rx_empty", 32'(rx_empty), 32'd1);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        miso_q.delete();
        cap_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
